// File: rtl/tis_pkg.sv
// -----------------------------------------------------------------------------
// tis_pkg
// Shared definitions for the TIS node fabric:
//   WORD_W / MAX_VAL  - word width and saturation magnitude of a TIS word
//   word_t            - signed TIS word
//   node_state_t      - handshake FSM states of a streaming node
//   saturate()        - clamp an integer to [-max_val, +max_val]
// -----------------------------------------------------------------------------
package tis_pkg;

  localparam int WORD_W  = 11;
  localparam int MAX_VAL = 999;

  typedef logic signed [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    OFFER,
    GAP
  } node_state_t;

  function automatic int saturate(input int value, input int max_val);
    if (value > max_val) begin
      return max_val;
    end else if (value < -max_val) begin
      return -max_val;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// -----------------------------------------------------------------------------
// stream_fifo
// Single-clock FIFO with an arbitrary (not necessarily power-of-two) depth.
// Ports:
//   clk, rst        - clock, asynchronous active-low clear of pointers/occupancy
//   push, data      - enqueue request and word; ignored while full
//   pop             - dequeue request; ignored while empty
//   head            - word at the read pointer (valid when !empty)
//   full, empty     - occupancy flags
// -----------------------------------------------------------------------------
module stream_fifo #(
  parameter int DEPTH = 39,
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occ;

  logic do_push;
  logic do_pop;

  assign full    = (occ == CNT_W'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // NOTE: storage is deliberately not reset; occupancy alone decides validity,
  // which keeps the array in plain RAM without a reset network.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;  // idle, or push and pop cancel out
      endcase
    end
  end

endmodule

// File: rtl/stream_in_node.sv
// -----------------------------------------------------------------------------
// stream_in_node
// Input-stream node: a host preloads TIS words into a FIFO, and after `start`
// the node offers them one at a time to a downstream core on the write/ack
// handshake (write = word offered, wready = one-cycle acknowledge).
// Ports:
//   clk, rst              - clock, asynchronous active-low reset
//   load_valid/load_data  - host enqueue; words are saturated to +/-MAXV
//   load_ready            - FIFO not full
//   start                 - one-cycle pulse, sets the sticky run flag
//   write, out            - offered word and its valid flag (out stable while write)
//   wready                - consumer acknowledge, only honoured while offering
//   count                 - words delivered since reset, saturating at 255
//   empty                 - FIFO holds no words (the out register is not counted)
//   done                  - sticky: stream ran dry after start
// -----------------------------------------------------------------------------
module stream_in_node
  import tis_pkg::*;
#(
  parameter int DEPTH = 39,
  parameter int WIDTH = WORD_W,
  parameter int MAXV  = MAX_VAL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic signed [WIDTH-1:0] load_data,
  output logic                    load_ready,
  input  logic                    start,
  output logic                    write,
  output logic signed [WIDTH-1:0] out,
  input  logic                    wready,
  output logic [7:0]              count,
  output logic                    empty,
  output logic                    done
);

  node_state_t             state;
  logic                    run;
  logic                    fifo_full;
  logic [WIDTH-1:0]        fifo_head;
  logic signed [WIDTH-1:0] load_sat;
  logic                    pop;

  // Signed widening keeps negative words negative before clamping.
  assign load_sat   = WIDTH'(saturate(int'(load_data), MAXV));
  assign load_ready = !fifo_full;
  assign pop        = (state == FETCH);

  stream_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (load_valid),
    .data  (load_sat),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (empty)
  );

  // write is a register with async clear, so asserting rst drops it at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      run   <= 1'b0;
      write <= 1'b0;
      out   <= '0;
      count <= '0;
      done  <= 1'b0;
    end else begin
      if (start) begin
        run <= 1'b1;
      end

      if (run && empty && (state == IDLE) && (count != '0)) begin
        done <= 1'b1;
      end

      case (state)
        IDLE: begin
          // Honouring start directly saves a cycle: FETCH right after the pulse.
          if ((run || start) && !empty) begin
            state <= FETCH;
          end
        end

        FETCH: begin
          out   <= fifo_head;
          write <= 1'b1;
          state <= OFFER;
        end

        OFFER: begin
          if (wready) begin
            write <= 1'b0;
            if (count != 8'hFF) begin
              count <= count + 8'd1;
            end
            state <= GAP;
          end
        end

        GAP: begin
          // One write-low cycle keeps back-to-back words distinguishable.
          state <= empty ? IDLE : FETCH;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_in_node.sv
module tb_stream_in_node;
  import tis_pkg::*;

  localparam int DEPTH = 39;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_valid = 1'b0;
  word_t      load_data = '0;
  logic       load_ready;
  logic       start = 1'b0;
  logic       write;
  word_t      out;
  logic       wready = 1'b0;
  logic [7:0] count;
  logic       empty;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Reference model: words still owed to the consumer, in order, and a tally.
  word_t exp_q[$];
  int    delivered = 0;

  always #5 clk = ~clk;

  stream_in_node #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W),
    .MAXV  (MAX_VAL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .start      (start),
    .write      (write),
    .out        (out),
    .wready     (wready),
    .count      (count),
    .empty      (empty),
    .done       (done)
  );

  function automatic word_t ref_sat(input int v);
    int r;
    r = v;
    if (v > 999) r = 999;
    if (v < -999) r = -999;
    return word_t'(r);
  endfunction

  function automatic logic [7:0] ref_count();
    return (delivered > 255) ? 8'd255 : 8'(delivered);
  endfunction

  // Observation point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    load_valid = 1'b0;
    start = 1'b0;
    wready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    exp_q.delete();
    delivered = 0;
  endtask

  task automatic load_word(input int v, input bit expect_accept);
    load_valid = 1'b1;
    load_data  = word_t'(v);
    if (expect_accept) exp_q.push_back(ref_sat(v));
    tick();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Consumer: acks each word after a random delay in [min_d, max_d] cycles of
  // write high, optionally toggles wready while nothing is offered, and
  // optionally loads one fresh word per cycle for the first `loads` cycles.
  task automatic collect(input int n, input int min_d, input int max_d,
                         input bit noise, input int loads);
    int    got = 0;
    int    budget = 0;
    int    wait_cnt = 0;
    int    delay = 0;
    int    loads_left;
    bit    just_acked = 1'b0;
    word_t held = '0;
    word_t exp;
    loads_left = loads;
    while (got < n && budget < 5000) begin
      wready = 1'b0;
      load_valid = 1'b0;
      if (just_acked) begin
        checks++;
        if (write !== 1'b0) begin
          errors++;
          $display("FAIL gap_after_ack: write=%b required 0", write);
        end
        just_acked = 1'b0;
      end
      if (loads_left > 0) begin
        checks++;
        if (load_ready !== 1'b1) begin
          errors++;
          $display("FAIL load_ready_streaming: got %b required 1", load_ready);
        end
        load_data  = word_t'($urandom);
        load_valid = 1'b1;
        exp_q.push_back(ref_sat(int'(load_data)));
        loads_left--;
      end
      if (write === 1'b1) begin
        if (wait_cnt == 0) begin
          held  = out;
          delay = $urandom_range(max_d, min_d);
        end else begin
          checks++;
          if (out !== held) begin
            errors++;
            $display("FAIL out_stable: got %0d required %0d", out, held);
          end
        end
        if (wait_cnt >= delay) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_word: got %0d required none", out);
          end else begin
            exp = exp_q.pop_front();
            if (out !== exp) begin
              errors++;
              $display("FAIL stream_word[%0d]: got %0d required %0d", delivered, out, exp);
            end
          end
          wready = 1'b1;
          got++;
          delivered++;
          wait_cnt = 0;
          just_acked = 1'b1;
        end else begin
          wait_cnt++;
        end
      end else begin
        if (wait_cnt != 0) begin
          checks++;
          errors++;
          $display("FAIL write_dropped: write fell after %0d cycles without ack", wait_cnt);
          wait_cnt = 0;
        end
        if (noise) wready = 1'($urandom_range(1, 0));
      end
      tick();
      budget++;
    end
    wready = 1'b0;
    load_valid = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL collect_timeout: got %0d words required %0d", got, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    load_valid = 1'b1;
    load_data = word_t'(5);
    start = 1'b1;
    repeat (3) tick();
    checks += 6;
    if (write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b required 0", write); end
    if (out !== '0) begin errors++; $display("FAIL reset_out: got %0d required 0", out); end
    if (count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d required 0", count); end
    if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b required 1", empty); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b required 1", load_ready); end
    load_valid = 1'b0;
    start = 1'b0;
    rst = 1'b1;
    repeat (5) tick();
    checks += 2;
    if (write !== 1'b0) begin errors++; $display("FAIL post_reset_idle_write: got %b required 0", write); end
    if (empty !== 1'b1) begin errors++; $display("FAIL post_reset_empty: got %b required 1", empty); end
    exp_q.delete();
    delivered = 0;
  endtask

  task automatic test_basic();
    do_reset();
    load_word(5, 1'b1);
    load_word(-3, 1'b1);
    load_word(999, 1'b1);
    repeat (3) tick();
    checks += 2;
    if (write !== 1'b0) begin errors++; $display("FAIL basic_no_stream_before_start: write=%b required 0", write); end
    if (empty !== 1'b0) begin errors++; $display("FAIL basic_loaded_empty: got %b required 0", empty); end
    pulse_start();
    checks++;
    if (write !== 1'b0) begin errors++; $display("FAIL basic_latency_c1: write=%b required 0", write); end
    tick();
    checks++;
    if (write !== 1'b1 || out !== word_t'(5)) begin
      errors++;
      $display("FAIL basic_latency_c2: write=%b out=%0d required write=1 out=5", write, out);
    end
    collect(3, 1, 1, 1'b0, 0);
    repeat (4) tick();
    checks += 3;
    if (count !== ref_count()) begin errors++; $display("FAIL basic_count: got %0d required %0d", count, ref_count()); end
    if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty: got %b required 1", empty); end
    if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b required 1", done); end
  endtask

  task automatic test_saturation_backpressure();
    do_reset();
    load_word(1023, 1'b1);
    load_word(-1024, 1'b1);
    pulse_start();
    collect(2, 7, 7, 1'b1, 0);
    repeat (6) begin
      wready = 1'($urandom_range(1, 0));
      tick();
    end
    wready = 1'b0;
    checks += 2;
    if (count !== ref_count()) begin errors++; $display("FAIL sat_count: got %0d required %0d", count, ref_count()); end
    if (done !== 1'b1) begin errors++; $display("FAIL sat_done: got %b required 1", done); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < DEPTH; i++) load_word(i, 1'b1);
    checks += 2;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL full_load_ready: got %b required 0", load_ready); end
    if (empty !== 1'b0) begin errors++; $display("FAIL full_empty: got %b required 0", empty); end
    load_word(77, 1'b0);
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL full_after_drop: load_ready=%b required 0", load_ready); end
    pulse_start();
    collect(DEPTH, 0, 0, 1'b0, 0);
    load_word(100, 1'b1);
    load_word(101, 1'b1);
    load_word(102, 1'b1);
    collect(3, 0, 0, 1'b0, 0);
    repeat (4) tick();
    checks += 4;
    if (count !== 8'd42) begin errors++; $display("FAIL wrap_count: got %0d required 42", count); end
    if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b required 1", empty); end
    if (done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b required 1", done); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_leftover: %0d words never streamed, required 0", exp_q.size()); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 3; i++) load_word(int'(word_t'($urandom)), 1'b1);
    pulse_start();
    collect(23, 0, 0, 1'b0, 20);
    repeat (4) tick();
    checks += 3;
    if (count !== ref_count()) begin errors++; $display("FAIL simul_count: got %0d required %0d", count, ref_count()); end
    if (empty !== 1'b1) begin errors++; $display("FAIL simul_empty: got %b required 1", empty); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL simul_leftover: %0d words never streamed, required 0", exp_q.size()); end
  endtask

  task automatic test_random();
    int k;
    int extra;
    do_reset();
    for (int r = 0; r < 5; r++) begin
      k = $urandom_range(8, 1);
      extra = $urandom_range(5, 0);
      for (int i = 0; i < k; i++) load_word(int'(word_t'($urandom)), 1'b1);
      pulse_start();
      collect(k + extra, 0, 3, 1'b1, extra);
    end
    repeat (4) tick();
    checks += 3;
    if (count !== ref_count()) begin errors++; $display("FAIL random_count: got %0d required %0d", count, ref_count()); end
    if (empty !== 1'b1) begin errors++; $display("FAIL random_empty: got %b required 1", empty); end
    if (done !== 1'b1) begin errors++; $display("FAIL random_done: got %b required 1", done); end
  endtask

  task automatic test_reset_mid_offer();
    int budget;
    do_reset();
    load_word(7, 1'b1);
    pulse_start();
    collect(1, 0, 0, 1'b0, 0);
    load_word(42, 1'b1);
    budget = 0;
    while (write !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    checks++;
    if (write !== 1'b1 || out !== word_t'(42)) begin
      errors++;
      $display("FAIL mid_offer_setup: write=%b out=%0d required write=1 out=42", write, out);
    end
    #2;
    rst = 1'b0;
    #1;
    checks += 3;
    if (write !== 1'b0) begin errors++; $display("FAIL async_reset_write: got %b required 0 before next edge", write); end
    if (count !== 8'd0) begin errors++; $display("FAIL async_reset_count: got %0d required 0", count); end
    if (out !== '0) begin errors++; $display("FAIL async_reset_out: got %0d required 0", out); end
    tick();
    tick();
    rst = 1'b1;
    exp_q.delete();
    delivered = 0;
    repeat (4) tick();
    checks += 2;
    if (empty !== 1'b1) begin errors++; $display("FAIL post_mid_reset_empty: got %b required 1", empty); end
    if (write !== 1'b0) begin errors++; $display("FAIL post_mid_reset_write: got %b required 0", write); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_saturation_backpressure();
    test_full_wrap();
    test_simultaneous();
    test_random();
    test_reset_mid_offer();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
